// File: rtl/lc4_iter_muldiv_if.sv
// Request/result handshake bundle for the LC4 iterative multiply/divide unit.
// The master issues operations and consumes results; the slave is the unit itself.
`timescale 1ns/1ps
interface lc4_iter_muldiv_if #(
    parameter int WIDTH = 16
);
    logic             i_valid;
    logic             o_ready;
    logic             i_op;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_flush;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_result;
    logic [WIDTH-1:0] o_remainder;
    logic             o_div_zero;

    modport master (
        output i_valid, i_op, i_a, i_b, i_flush, i_ready,
        input  o_ready, o_valid, o_result, o_remainder, o_div_zero
    );

    modport slave (
        input  i_valid, i_op, i_a, i_b, i_flush, i_ready,
        output o_ready, o_valid, o_result, o_remainder, o_div_zero
    );
endinterface

// File: rtl/lc4_iter_muldiv.sv
// Radix-2 iterative unsigned multiply (shift-add) / divide (restoring) unit.
// One bit per BUSY cycle; DIV returns quotient and remainder together.
`timescale 1ns/1ps
module lc4_iter_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lc4_iter_muldiv_if.slave     bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             dz_q, dz_d;

    // a_q: multiplicand (MUL) or dividend shifting into quotient (DIV)
    // b_q: multiplier shifting right (MUL) or divisor (DIV)
    logic             op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    logic [WIDTH-1:0] mul_acc_nxt;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             rem_ge;
    logic [WIDTH-1:0] div_rem_nxt;
    logic [WIDTH-1:0] div_quo_nxt;

    assign mul_acc_nxt = b_q[0] ? (acc_q + a_q) : acc_q;

    // The borrow out of the WIDTH+1-bit subtraction decides the quotient bit.
    assign rem_shift   = {rem_q, a_q[WIDTH-1]};
    assign rem_diff    = rem_shift - {1'b0, b_q};
    assign rem_ge      = ~rem_diff[WIDTH];
    assign div_rem_nxt = rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign div_quo_nxt = {a_q[WIDTH-2:0], rem_ge};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        remo_d  = remo_q;
        dz_d    = dz_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        rem_d   = rem_q;

        case (state_q)
            S_IDLE: begin
                if (bus.i_valid) begin
                    op_d  = bus.i_op;
                    a_d   = bus.i_a;
                    b_d   = bus.i_b;
                    acc_d = '0;
                    rem_d = '0;
                    if (bus.i_op && (bus.i_b == '0)) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                        res_d   = '0;
                        remo_d  = '0;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = CNT_W'(WIDTH);
                        dz_d    = 1'b0;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (op_q) begin
                    a_d   = div_quo_nxt;
                    rem_d = div_rem_nxt;
                end else begin
                    acc_d = mul_acc_nxt;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    res_d   = op_q ? div_quo_nxt : mul_acc_nxt;
                    remo_d  = op_q ? div_rem_nxt : '0;
                end
            end
            S_DONE: begin
                if (bus.i_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush overrides everything, including a request in the same cycle.
        if (bus.i_flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            res_d   = '0;
            remo_d  = '0;
            dz_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            remo_q  <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            remo_q  <= remo_d;
            dz_q    <= dz_d;
        end
    end

    // Working registers are always reloaded at accept, so they need no reset.
    always_ff @(posedge clk) begin
        op_q  <= op_d;
        a_q   <= a_d;
        b_q   <= b_d;
        acc_q <= acc_d;
        rem_q <= rem_d;
    end

    assign bus.o_ready     = (state_q == S_IDLE);
    assign bus.o_valid     = (state_q == S_DONE);
    assign bus.o_result    = res_q;
    assign bus.o_remainder = remo_q;
    assign bus.o_div_zero  = dz_q;

endmodule

// File: tb/tb_lc4_iter_muldiv.sv
// Directed and table-driven bench for lc4_iter_muldiv at WIDTH 16 and 8,
// covering latency, backpressure, reset/flush aborts and a small random sweep.
`timescale 1ns/1ps
module tb_lc4_iter_muldiv;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lc4_iter_muldiv_if #(.WIDTH(16)) bus16();
    lc4_iter_muldiv_if #(.WIDTH(8))  bus8();

    lc4_iter_muldiv #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    lc4_iter_muldiv #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [15:0] rem;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic drv(input int w, input logic v, input logic op, input logic [63:0] a, input logic [63:0] b);
        if (w == 16) begin
            bus16.i_valid = v; bus16.i_op = op; bus16.i_a = a[15:0]; bus16.i_b = b[15:0];
        end else begin
            bus8.i_valid = v; bus8.i_op = op; bus8.i_a = a[7:0]; bus8.i_b = b[7:0];
        end
    endtask

    task automatic set_irdy(input int w, input logic r);
        if (w == 16) bus16.i_ready = r; else bus8.i_ready = r;
    endtask

    function automatic logic rd_ready(input int w);
        return (w == 16) ? bus16.o_ready : bus8.o_ready;
    endfunction
    function automatic logic rd_valid(input int w);
        return (w == 16) ? bus16.o_valid : bus8.o_valid;
    endfunction
    function automatic logic [63:0] rd_res(input int w);
        return (w == 16) ? {48'b0, bus16.o_result} : {56'b0, bus8.o_result};
    endfunction
    function automatic logic [63:0] rd_rem(input int w);
        return (w == 16) ? {48'b0, bus16.o_remainder} : {56'b0, bus8.o_remainder};
    endfunction
    function automatic logic rd_dz(input int w);
        return (w == 16) ? bus16.o_div_zero : bus8.o_div_zero;
    endfunction

    // Counts edges starting with the accept edge as 1 until o_valid is seen.
    task automatic wait_valid(input int w, output int lat);
        lat = 1;
        while (!rd_valid(w) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_op(input int w, input logic op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] er, input logic [63:0] erem, input logic edz,
                         input int elat, input int stall, input string nm);
        int lat;
        lat = 0;
        while (!rd_ready(w) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " ready_before"}, {63'b0, rd_ready(w)}, 64'd1);
        @(negedge clk);
        drv(w, 1'b1, op, a, b);
        set_irdy(w, 1'b0);
        @(posedge clk); #1;
        drv(w, 1'b0, ~op, ~a, ~b);
        wait_valid(w, lat);
        chk({nm, " latency"}, 64'(lat), 64'(elat));
        chk({nm, " result"}, rd_res(w), er);
        chk({nm, " remainder"}, rd_rem(w), erem);
        chk({nm, " div_zero"}, {63'b0, rd_dz(w)}, {63'b0, edz});
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk({nm, " hold_valid"}, {63'b0, rd_valid(w)}, 64'd1);
            chk({nm, " hold_result"}, rd_res(w), er);
        end
        @(negedge clk);
        set_irdy(w, 1'b1);
        @(posedge clk); #1;
        chk({nm, " handoff_valid"}, {63'b0, rd_valid(w)}, 64'd0);
        chk({nm, " handoff_ready"}, {63'b0, rd_ready(w)}, 64'd1);
        @(negedge clk);
        set_irdy(w, 1'b0);
    endtask

    task automatic chk_cleared(input string nm);
        chk({nm, " ready"}, {63'b0, bus16.o_ready}, 64'd1);
        chk({nm, " valid"}, {63'b0, bus16.o_valid}, 64'd0);
        chk({nm, " result"}, {48'b0, bus16.o_result}, 64'd0);
        chk({nm, " remainder"}, {48'b0, bus16.o_remainder}, 64'd0);
        chk({nm, " div_zero"}, {63'b0, bus16.o_div_zero}, 64'd0);
    endtask

    task automatic watch_no_valid(input string nm);
        int seen;
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (bus16.o_valid) seen++;
        end
        chk(nm, 64'(seen), 64'd0);
    endtask

    initial begin
        int lat;
        drv(16, 1'b0, 1'b0, 64'd0, 64'd0);
        drv(8, 1'b0, 1'b0, 64'd0, 64'd0);
        set_irdy(16, 1'b0);
        set_irdy(8, 1'b0);
        bus16.i_flush = 1'b0;
        bus8.i_flush  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_cleared("reset");
        chk("reset8 ready", {63'b0, bus8.o_ready}, 64'd1);
        chk("reset8 valid", {63'b0, bus8.o_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        vecs[0]  = '{1'b1, 16'd100,   16'd7,     16'd14,     16'd2, 1'b0, 17};
        vecs[1]  = '{1'b0, 16'h1234,  16'h0010,  16'h2340,   16'd0, 1'b0, 17};
        vecs[2]  = '{1'b0, 16'hFFFF,  16'hFFFF,  16'h0001,   16'd0, 1'b0, 17};
        vecs[3]  = '{1'b1, 16'h00FF,  16'h0000,  16'h0000,   16'd0, 1'b1, 1};
        vecs[4]  = '{1'b1, 16'hFFFF,  16'h0001,  16'hFFFF,   16'd0, 1'b0, 17};
        vecs[5]  = '{1'b1, 16'd5,     16'd9,     16'd0,      16'd5, 1'b0, 17};
        vecs[6]  = '{1'b0, 16'd0,     16'h1234,  16'd0,      16'd0, 1'b0, 17};
        vecs[7]  = '{1'b1, 16'hFFFF,  16'hFFFF,  16'd1,      16'd0, 1'b0, 17};
        vecs[8]  = '{1'b1, 16'h8000,  16'd3,     16'h2AAA,   16'd2, 1'b0, 17};
        vecs[9]  = '{1'b0, 16'h00FF,  16'h0101,  16'hFFFF,   16'd0, 1'b0, 17};
        vecs[10] = '{1'b0, 16'd7,     16'd0,     16'd0,      16'd0, 1'b0, 17};
        vecs[11] = '{1'b1, 16'd1000,  16'd10,    16'd100,    16'd0, 1'b0, 17};

        for (int i = 0; i < 12; i++) begin
            do_op(16, vecs[i].op, 64'(vecs[i].a), 64'(vecs[i].b), 64'(vecs[i].res),
                  64'(vecs[i].rem), vecs[i].dz, vecs[i].lat, i % 3, $sformatf("vec%0d", i));
        end

        // Backpressure: a request held during DONE must not be taken.
        @(negedge clk);
        drv(16, 1'b1, 1'b1, 64'd100, 64'd7);
        @(posedge clk); #1;
        drv(16, 1'b0, 1'b0, 64'd0, 64'd0);
        wait_valid(16, lat);
        chk("bp latency", 64'(lat), 64'd17);
        @(negedge clk);
        drv(16, 1'b1, 1'b1, 64'd31, 64'd2);
        for (int s = 0; s < 5; s++) begin
            @(posedge clk); #1;
            chk("bp valid", {63'b0, bus16.o_valid}, 64'd1);
            chk("bp ready", {63'b0, bus16.o_ready}, 64'd0);
            chk("bp result", {48'b0, bus16.o_result}, 64'd14);
            chk("bp remainder", {48'b0, bus16.o_remainder}, 64'd2);
        end
        @(negedge clk);
        set_irdy(16, 1'b1);
        @(posedge clk); #1;
        chk("bp idle ready", {63'b0, bus16.o_ready}, 64'd1);
        chk("bp idle valid", {63'b0, bus16.o_valid}, 64'd0);
        @(negedge clk);
        set_irdy(16, 1'b0);
        @(posedge clk); #1;
        chk("bp accept ready", {63'b0, bus16.o_ready}, 64'd0);
        drv(16, 1'b0, 1'b0, 64'd0, 64'd0);
        wait_valid(16, lat);
        chk("bp2 latency", 64'(lat), 64'd17);
        chk("bp2 result", {48'b0, bus16.o_result}, 64'd15);
        chk("bp2 remainder", {48'b0, bus16.o_remainder}, 64'd1);
        @(negedge clk);
        set_irdy(16, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        set_irdy(16, 1'b0);

        // Reset in the middle of a divide.
        @(negedge clk);
        drv(16, 1'b1, 1'b1, 64'd100, 64'd7);
        @(posedge clk); #1;
        drv(16, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_cleared("rst_busy");
        @(negedge clk);
        rst_n = 1'b1;
        watch_no_valid("rst_busy no_valid");

        do_op(16, 1'b0, 64'd3, 64'd5, 64'd15, 64'd0, 1'b0, 17, 0, "pre_flush");

        // Divide-by-zero result cleared by flush in DONE, then flush beats a request.
        @(negedge clk);
        drv(16, 1'b1, 1'b1, 64'h00FF, 64'd0);
        @(posedge clk); #1;
        drv(16, 1'b0, 1'b0, 64'd0, 64'd0);
        chk("dz valid", {63'b0, bus16.o_valid}, 64'd1);
        chk("dz flag", {63'b0, bus16.o_div_zero}, 64'd1);
        @(negedge clk);
        bus16.i_flush = 1'b1;
        @(posedge clk); #1;
        chk_cleared("flush_done");
        @(negedge clk);
        drv(16, 1'b1, 1'b0, 64'd3, 64'd5);
        @(posedge clk); #1;
        chk("flush_req ready", {63'b0, bus16.o_ready}, 64'd1);
        @(negedge clk);
        bus16.i_flush = 1'b0;
        drv(16, 1'b0, 1'b0, 64'd0, 64'd0);

        do_op(16, 1'b0, 64'd3, 64'd5, 64'd15, 64'd0, 1'b0, 17, 1, "pre_flush2");

        // Flush in the middle of a multiply.
        @(negedge clk);
        drv(16, 1'b1, 1'b0, 64'h1234, 64'h0010);
        @(posedge clk); #1;
        drv(16, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus16.i_flush = 1'b1;
        @(posedge clk); #1;
        chk_cleared("flush_busy");
        @(negedge clk);
        bus16.i_flush = 1'b0;
        watch_no_valid("flush_busy no_valid");

        do_op(8, 1'b1, 64'hFF, 64'h01, 64'hFF, 64'd0, 1'b0, 9, 1, "w8 ff_div_1");
        do_op(8, 1'b1, 64'd3, 64'd200, 64'd0, 64'd3, 1'b0, 9, 0, "w8 a_lt_b");
        do_op(8, 1'b0, 64'hFF, 64'hFF, 64'h01, 64'd0, 1'b0, 9, 2, "w8 mul_ff");

        for (int i = 0; i < 24; i++) begin
            int          w;
            logic [63:0] mask, a, b, er, erem;
            logic        op, edz;
            int          elat;
            w    = (i % 2 == 1) ? 8 : 16;
            mask = (w == 16) ? 64'hFFFF : 64'hFF;
            a    = 64'($urandom) & mask;
            b    = (i % 7 == 3) ? 64'd0 : (64'($urandom) & mask);
            if (i % 5 == 2) b = b >> (w / 2);
            op   = 1'($urandom_range(0, 1));
            edz  = op && (b == 64'd0);
            if (!op) begin
                er = (a * b) & mask; erem = 64'd0; elat = w + 1;
            end else if (edz) begin
                er = 64'd0; erem = 64'd0; elat = 1;
            end else begin
                er = a / b; erem = a % b; elat = w + 1;
            end
            do_op(w, op, a, b, er, erem, edz, elat, int'($urandom_range(0, 3)),
                  $sformatf("rand%0d w%0d op%0d a%0h b%0h", i, w, op, a, b));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
